gf_alu: RTL
===========

// Module: gf_alu
// PURPOSE
//  Parametrised GF(p) arithmetic unit, next generation of the 32-bit field unit: add, sub, mul, div over
//  odd prime p < 2^WIDTH. One op in flight, valid/ready issue, single-cycle o_valid completion pulse.
//  Serves the ECC point-arithmetic controller. MUL returns true a*b mod p, with no 2^-W scaling.
// PARAMETERS
//  WIDTH     32          field element / prime width in bits (>= 8)
//  DIV_MAX   4*WIDTH     DIV iteration bound; exceeding it flags o_err
// PORTS
//  i_clk     in   1      clock
//  i_rst     in   1      asynchronous active-low reset
//  i_valid   in   1      request valid; accepted when i_valid && o_ready
//  o_ready   out  1      unit idle, can accept
//  i_op      in   2      0 ADD, 1 SUB, 2 MUL, 3 DIV (a/b)
//  i_a       in   WIDTH  operand a, required < p
//  i_b       in   WIDTH  operand b, required < p
//  i_prime   in   WIDTH  modulus p, odd; sampled at accept, ignored while busy
//  o_valid   out  1      one-cycle completion pulse
//  o_result  out  WIDTH  result, held from o_valid until next completion
//  o_err     out  1      error flag, qualified by o_valid
// BEHAVIOUR
//  Clock: single i_clk. Reset: i_rst is asynchronous, active-low.
//  Reset values: o_ready=1, o_valid=0, o_result=0, o_err=0, FSM=IDLE, all working regs 0.
//  Reset asserted mid-op aborts the op. No o_valid is produced for it.
//  FSM states: IDLE, MUL, DIV. o_ready = (state==IDLE).
//  - Accept at cycle T. Back-to-back issue is legal in the o_valid cycle.
//  - i_a, i_b, i_op, i_prime are latched at accept. Changes while busy are ignored.
//  ADD: s = a+b in WIDTH+1 bits; s>=p ? s-p : s. o_valid at T+1. Stays IDLE.
//  SUB: a>=b ? a-b : a-b+p, in WIDTH+1 bits. o_valid at T+1.
//  MUL: MSB-first double-and-add, r=0. One bit per cycle, i=WIDTH-1..0:
//    r=2r mod p; if b[i], r=(r+a) mod p.
//    Two conditional subtractions per cycle. Cycles T+1..T+WIDTH. o_valid at T+WIDTH+1.
//  DIV: binary extended Euclid. Init u=b, v=p, x1=a, x2=0.
//    One step per cycle, first matching rule applies:
//    - u even: u>>=1; x1 = x1 even ? x1>>1 : (x1+p)>>1, with x1+p in WIDTH+1 bits.
//    - v even: same rule on v, x2.
//    - u>=v: u-=v; x1=(x1-x2) mod p.
//    - else: v-=u; x2=(x2-x1) mod p.
//    - Before each step: u==1 -> result x1; v==1 -> result x2; return to IDLE, o_valid next cycle.
//    Latency is data dependent, <= DIV_MAX+1 cycles.
//  DIV by zero (b==0 at accept): no iteration; o_valid at T+1, o_err=1, o_result=0.
//  DIV exceeding DIV_MAX steps (gcd(b,p)!=1, i.e. p not prime): o_valid, o_err=1, o_result=0.
//  o_err=0 on every other completion.
//  Out-of-range operands (a>=p or b>=p): result unspecified, latency and handshake still hold.
// CONFIGURATION
//  GF_ALU_DIV_EN defined:
//    DIV datapath present (u, v, x1, x2, step counter); behaviour as above.
//  GF_ALU_DIV_EN undefined:
//    DIV state and registers are removed.
//    i_op==3 completes like ADD: o_valid at T+1, o_err=1, o_result=0.
// STRUCTURE
//  gf_alu_pkg holds:
//    - op encoding typedef gf_op_e (GF_ADD, GF_SUB, GF_MUL, GF_DIV)
//    - FSM state typedef
//    - localparam for default WIDTH
//  Sub-module gf_mod_addsub: combinational (x +/- y) mod p in WIDTH+1 bits.
//    Instantiated for ADD/SUB, for both MUL step halves, and for the DIV x-updates.
// TESTING
//  (WIDTH=32, p=0xFFFFFFFB unless stated)
//  - ADD a=p-1, b=2 -> o_result=1, o_valid at T+1, o_err=0.
//  - SUB a=3, b=5 -> 0xFFFFFFF9. Then issue ADD in the o_valid cycle; it is accepted.
//  - MUL a=0x10000, b=0x10000 -> 5, o_valid exactly at T+33.
//    WIDTH=8, p=7: MUL 3*5 -> 1 at T+9.
//  - DIV a=1, b=2 -> 0x7FFFFFFE. DIV a=6, b=3 -> 2. Both within DIV_MAX+1 cycles, o_err=0.
//  - DIV b=0 -> o_valid at T+1, o_err=1, o_result=0.
//    p=15, DIV a=1, b=5 -> o_err=1 after timeout.
//    Without GF_ALU_DIV_EN: any DIV -> o_err=1 at T+1.
//  - Assert i_rst at T+10 of a MUL -> no o_valid. After release: o_ready=1, o_result=0; next ADD correct.

Source files
------------

// File: rtl/gf_alu_pkg.sv
// Shared types for the GF(p) arithmetic unit: op encoding, FSM states, default width.
// The DIV state only exists when GF_ALU_DIV_EN is defined.
package gf_alu_pkg;

  localparam int GF_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    GF_ADD = 2'd0,
    GF_SUB = 2'd1,
    GF_MUL = 2'd2,
    GF_DIV = 2'd3
  } gf_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef GF_ALU_DIV_EN
    ,
    ST_DIV  = 2'd2
`endif
  } gf_state_e;

endpackage

// File: rtl/gf_alu_if.sv
// Request/response bundle of gf_alu; the master issues operations, the slave is the unit.
interface gf_alu_if
  import gf_alu_pkg::*;
#(
  parameter int WIDTH = GF_WIDTH_DEFAULT
) ();
  // A request transfers on the clock edge where i_valid && o_ready; the master keeps
  // i_op/i_a/i_b/i_prime stable while i_valid is high. o_valid is a one-cycle pulse,
  // o_result/o_err are held until the next completion and o_err is meaningful only with o_valid.
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_prime;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_err;

  modport master (
    output i_valid, i_op, i_a, i_b, i_prime,
    input  o_ready, o_valid, o_result, o_err
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_prime,
    output o_ready, o_valid, o_result, o_err
  );
endinterface

// File: rtl/gf_mod_addsub.sv
// Combinational (x +/- y) mod p for x, y < p; the add path needs one extra carry bit.
module gf_mod_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  input  logic             sub,
  output logic [WIDTH-1:0] z
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    z   = '0;
    if (sub) begin
      // x - y + p is below 2^WIDTH, so wrapping WIDTH-bit arithmetic is exact here
      z = (x >= y) ? (x - y) : (x - y + p);
    end else begin
      z = (sum >= {1'b0, p}) ? WIDTH'(sum - {1'b0, p}) : sum[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/gf_alu.sv
// gf_alu: GF(p) add/sub/mul/div unit, one op in flight, valid/ready issue, o_valid pulse.
// Define GF_ALU_DIV_EN to build the binary extended Euclid DIV datapath.
module gf_alu
  import gf_alu_pkg::*;
#(
  parameter int WIDTH   = GF_WIDTH_DEFAULT,
  parameter int DIV_MAX = 4 * WIDTH
) (
  input  logic      i_clk,
  input  logic      i_rst,
  gf_alu_if.slave   bus,
  output gf_state_e dbg_state
);
  localparam int IW = $clog2(WIDTH);

  gf_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] as0_x, as0_y, as0_p, as0_z, as1_z, mul_z;
  logic             as0_sub;
  gf_op_e           op_in;

  assign op_in = gf_op_e'(bus.i_op);

  // Idle: first adder serves ADD/SUB on the request; MUL: it doubles r and the second adds a
  always_comb begin
    as0_x   = bus.i_a;
    as0_y   = bus.i_b;
    as0_p   = bus.i_prime;
    as0_sub = (op_in == GF_SUB);
    if (state_q == ST_MUL) begin
      as0_x   = r_q;
      as0_y   = r_q;
      as0_p   = p_q;
      as0_sub = 1'b0;
    end
  end

  gf_mod_addsub #(.WIDTH(WIDTH)) u_as0 (.x(as0_x), .y(as0_y), .p(as0_p), .sub(as0_sub), .z(as0_z));
  gf_mod_addsub #(.WIDTH(WIDTH)) u_as1 (.x(as0_z), .y(a_q), .p(p_q), .sub(1'b0), .z(as1_z));

  assign mul_z = b_q[idx_q] ? as1_z : as0_z;

`ifdef GF_ALU_DIV_EN
  localparam int CW = $clog2(DIV_MAX + 1);

  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] x1_h, x2_h, xs_z;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             u_ge_v;

  assign u_ge_v = (u_q >= v_q);
  // Halving mod p: odd values get p added first so the shift stays exact
  assign x1_h = WIDTH'(({1'b0, x1_q} + (x1_q[0] ? {1'b0, p_q} : {(WIDTH+1){1'b0}})) >> 1);
  assign x2_h = WIDTH'(({1'b0, x2_q} + (x2_q[0] ? {1'b0, p_q} : {(WIDTH+1){1'b0}})) >> 1);

  gf_mod_addsub #(.WIDTH(WIDTH)) u_as_div (
    .x(u_ge_v ? x1_q : x2_q), .y(u_ge_v ? x2_q : x1_q), .p(p_q), .sub(1'b1), .z(xs_z)
  );
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    r_d      = r_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    result_d = result_q;
`ifdef GF_ALU_DIV_EN
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          a_d = bus.i_a;
          b_d = bus.i_b;
          p_d = bus.i_prime;
          case (op_in)
            GF_ADD, GF_SUB: begin
              valid_d  = 1'b1;
              result_d = as0_z;
              err_d    = 1'b0;
            end
            GF_MUL: begin
              state_d = ST_MUL;
              r_d     = '0;
              idx_d   = IW'(WIDTH - 1);
            end
            default: begin
`ifdef GF_ALU_DIV_EN
              if (bus.i_b == '0) begin
                valid_d  = 1'b1;
                result_d = '0;
                err_d    = 1'b1;
              end else begin
                state_d = ST_DIV;
                u_d     = bus.i_b;
                v_d     = bus.i_prime;
                x1_d    = bus.i_a;
                x2_d    = '0;
                cnt_d   = '0;
              end
`else
              valid_d  = 1'b1;
              result_d = '0;
              err_d    = 1'b1;
`endif
            end
          endcase
        end
      end
      ST_MUL: begin
        r_d   = mul_z;
        idx_d = idx_q - IW'(1);
        if (idx_q == '0) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = mul_z;
          err_d    = 1'b0;
        end
      end
`ifdef GF_ALU_DIV_EN
      ST_DIV: begin
        if (u_q == WIDTH'(1) || v_q == WIDTH'(1)) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = (u_q == WIDTH'(1)) ? x1_q : x2_q;
          err_d    = 1'b0;
        end else if (cnt_q == CW'(DIV_MAX)) begin
          // Only reachable when gcd(b, p) != 1, i.e. p was not prime
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = x1_h;
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = x2_h;
          end else if (u_ge_v) begin
            u_d  = u_q - v_q;
            x1_d = xs_z;
          end else begin
            v_d  = v_q - u_q;
            x2_d = xs_z;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef GF_ALU_DIV_EN
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef GF_ALU_DIV_EN
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_err    = err_q;
  assign dbg_state    = state_q;
endmodule
